// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receive controller with 16x oversampling.
// Owns the baud generator's config and hands bytes out via valid/ready.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   cfg_baud_rate     requested rate (00=2400 .. 11=19200)
//   cfg_update        one-cycle pulse, captures cfg_baud_rate as pending
//   gen_baud_rate     baud select driven to the generator
//   gen_reset_n       active-low generator reset
//   baud_clk          generator toggle output, rising edge = one 16x tick
//   rx_serial         asynchronous serial line, idle high
//   rx_data/rx_valid  one-entry holding register for the received byte
//   rx_ready          consumer accept
//   framing_err       one-cycle pulse on a bad stop bit
//   overrun_err       one-cycle pulse when a byte is dropped
//   busy              high whenever the controller is not idle
module uart_rx_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] cfg_baud_rate,
   input  logic       cfg_update,
   output logic [1:0] gen_baud_rate,
   output logic       gen_reset_n,
   input  logic       baud_clk,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_err,
   output logic       overrun_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH,
      RECONF
   } state_t;

   state_t state;
   state_t state_nx;

   logic       sync_q;
   logic       line_s;
   logic       baud_clk_q;
   logic       tick;
   logic [3:0] tick_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       pend;
   logic [1:0] pend_rate;
   logic       rc_cnt;

   logic cnt_clr;
   logic cnt_inc;
   logic shift_en;
   logic bit_clr;
   logic deliver;
   logic frm_err;
   logic reconf_go;
   logic reconf_done;

   assign tick = baud_clk && !baud_clk_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      shift_en    = 1'b0;
      bit_clr     = 1'b0;
      deliver     = 1'b0;
      frm_err     = 1'b0;
      reconf_go   = 1'b0;
      reconf_done = 1'b0;
      unique case (state)
         IDLE: begin
            // pending reconfiguration wins over a start edge
            if (pend) begin
               state_nx  = RECONF;
               reconf_go = 1'b1;
            end else if (!line_s) begin
               state_nx = START;
               cnt_clr  = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == 4'd7) begin
                  cnt_clr = 1'b1;
                  if (!line_s) begin
                     state_nx = DATA;
                     bit_clr  = 1'b1;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt == 4'd15) begin
                  cnt_clr  = 1'b1;
                  shift_en = 1'b1;
                  if (bit_idx == 3'd7) begin
                     state_nx = STOP;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt == 4'd15) begin
                  cnt_clr = 1'b1;
                  if (line_s) begin
                     deliver  = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     frm_err  = 1'b1;
                     state_nx = WAIT_HIGH;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         WAIT_HIGH: begin
            // a held-low line (break) must not look like a new start
            if (line_s) begin
               state_nx = IDLE;
            end
         end
         RECONF: begin
            if (rc_cnt) begin
               reconf_done = 1'b1;
               state_nx    = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q        <= 1'b1;
         line_s        <= 1'b1;
         baud_clk_q    <= 1'b0;
         tick_cnt      <= 4'd0;
         bit_idx       <= 3'd0;
         shreg         <= 8'd0;
         pend          <= 1'b0;
         pend_rate     <= 2'b10;
         rc_cnt        <= 1'b0;
         gen_baud_rate <= 2'b10;
         gen_reset_n   <= 1'b0;
         rx_data       <= 8'd0;
         rx_valid      <= 1'b0;
         framing_err   <= 1'b0;
         overrun_err   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         sync_q <= rx_serial;
         line_s <= sync_q;

         // generator restarts low, so forget its last level
         baud_clk_q <= reconf_go ? 1'b0 : baud_clk;

         if (cnt_clr) begin
            tick_cnt <= 4'd0;
         end else if (cnt_inc) begin
            tick_cnt <= tick_cnt + 4'd1;
         end

         if (bit_clr) begin
            bit_idx <= 3'd0;
         end else if (shift_en) begin
            bit_idx <= bit_idx + 3'd1;
         end

         if (shift_en) begin
            shreg <= {line_s, shreg[7:1]};
         end

         // an update in the entry cycle is newer, keep it pending
         if (cfg_update) begin
            pend      <= 1'b1;
            pend_rate <= cfg_baud_rate;
         end else if (reconf_go) begin
            pend <= 1'b0;
         end

         if (reconf_go) begin
            rc_cnt <= 1'b0;
         end else if (state == RECONF) begin
            rc_cnt <= 1'b1;
         end

         if (reconf_go) begin
            gen_baud_rate <= pend_rate;
         end

         gen_reset_n <= !(reconf_go ||
                          (state == RECONF && !reconf_done));

         framing_err <= frm_err;
         overrun_err <= 1'b0;

         if (deliver) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         busy <= (state_nx != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl.
// Models the baud generator and checks bytes through a scoreboard.
module tb_uart_rx_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] cfg_baud_rate;
   logic       cfg_update;
   logic [1:0] gen_baud_rate;
   logic       gen_reset_n;
   logic       baud_clk;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       framing_err;
   logic       overrun_err;
   logic       busy;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   int vcnt   = 0;
   int fcnt   = 0;
   int ocnt   = 0;
   int pops   = 0;
   int lowcnt = 0;
   int lowrun = 0;
   int lastrun = 0;

   bit fast = 1'b0;
   int half;
   int gcnt;

   always #10 clock = ~clock;

   uart_rx_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .cfg_baud_rate (cfg_baud_rate),
      .cfg_update    (cfg_update),
      .gen_baud_rate (gen_baud_rate),
      .gen_reset_n   (gen_reset_n),
      .baud_clk      (baud_clk),
      .rx_serial     (rx_serial),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .framing_err   (framing_err),
      .overrun_err   (overrun_err),
      .busy          (busy)
   );

   // 50 MHz generator model; fast mode shortens ticks to 8 clocks
   always_comb begin
      if (fast) begin
         half = 4;
      end else begin
         case (gen_baud_rate)
            2'b00:   half = 651;
            2'b01:   half = 326;
            2'b10:   half = 163;
            default: half = 82;
         endcase
      end
   end

   always @(posedge clock) begin
      if (!gen_reset_n) begin
         gcnt     <= 0;
         baud_clk <= 1'b0;
      end else if (gcnt >= half - 1) begin
         gcnt     <= 0;
         baud_clk <= ~baud_clk;
      end else begin
         gcnt <= gcnt + 1;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stopv);
      int b;
      b = 32 * half;
      rx_serial = 1'b0;
      cyc(b);
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         cyc(b);
      end
      rx_serial = stopv;
      cyc(b);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         cyc(1);
         n++;
      end
      total++;
      assert (!busy) else begin
         bad++;
         $error("FAIL wait_idle observed=busy expected=idle");
      end
   endtask

   task automatic cfg_pulse(input logic [1:0] r);
      cfg_baud_rate = r;
      cfg_update    = 1'b1;
      cyc(1);
      cfg_update    = 1'b0;
   endtask

   // monitor: handshakes, error pulses, gen_reset_n low runs
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (rx_valid) vcnt++;
            if (framing_err) fcnt++;
            if (overrun_err) ocnt++;
            if (!gen_reset_n) begin
               lowcnt++;
               lowrun++;
            end else if (lowrun != 0) begin
               lastrun = lowrun;
               lowrun  = 0;
            end
            if (rx_valid && rx_ready) begin
               total++;
               assert (sb.size() != 0) else begin
                  bad++;
                  $error("FAIL unexpected_byte observed=%0h expected=none",
                         rx_data);
               end
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("rx_byte", {24'd0, rx_data}, {24'd0, e});
                  pops++;
               end
            end
         end
      end
   end

   initial begin
      int sv;
      int sf;
      int so;
      int sp;
      int sl;

      reset         = 1'b1;
      cfg_baud_rate = 2'b00;
      cfg_update    = 1'b0;
      rx_serial     = 1'b1;
      rx_ready      = 1'b1;
      cyc(3);

      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_framing", framing_err, 0);
      chk("rst_overrun", overrun_err, 0);
      chk("rst_gen_rate", gen_baud_rate, 2'b10);
      chk("rst_gen_rst_n", gen_reset_n, 0);

      reset = 1'b0;
      cyc(1);
      chk("gen_rst_release", gen_reset_n, 1);

      // configure 19200
      sl = lowcnt;
      cfg_pulse(2'b11);
      cyc(10);
      chk("cfg_rate", gen_baud_rate, 2'b11);
      chk("cfg_low_run", lastrun, 2);
      chk("cfg_low_total", lowcnt - sl, 2);
      cyc(400);

      // 0x5A at real 19200 timing
      sv = vcnt; sf = fcnt; sp = pops;
      sb.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_idle(100);
      cyc(4);
      chk("b5a_pops", pops - sp, 1);
      chk("b5a_valid_cycles", vcnt - sv, 1);
      chk("b5a_framing", fcnt - sf, 0);
      chk("b5a_valid_low", rx_valid, 0);

      fast = 1'b1;
      cyc(64);

      // glitch: low for 3 ticks
      sv = vcnt; sf = fcnt;
      rx_serial = 1'b0;
      cyc(6);
      chk("glitch_busy", busy, 1);
      cyc(18);
      rx_serial = 1'b1;
      cyc(80);
      chk("glitch_idle", busy, 0);
      chk("glitch_no_valid", vcnt - sv, 0);
      chk("glitch_no_frm", fcnt - sf, 0);

      // framing error, line held low an extra bit
      sv = vcnt; sf = fcnt;
      send_frame(8'hA3, 1'b0);
      cyc(128);
      chk("frm_wait_high", busy, 1);
      chk("frm_pulses", fcnt - sf, 1);
      chk("frm_no_valid", vcnt - sv, 0);
      chk("frm_data_kept", rx_data, 8'h5A);
      rx_serial = 1'b1;
      cyc(6);
      chk("frm_idle", busy, 0);
      sp = pops;
      sb.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      wait_idle(100);
      cyc(4);
      chk("b11_pops", pops - sp, 1);

      // overrun
      rx_ready = 1'b0;
      so = ocnt; sp = pops;
      sb.push_back(8'h01);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      wait_idle(100);
      cyc(4);
      chk("ovr_pulses", ocnt - so, 1);
      chk("ovr_data", rx_data, 8'h01);
      chk("ovr_valid", rx_valid, 1);
      rx_ready = 1'b1;
      cyc(2);
      chk("ovr_drain", rx_valid, 0);
      sb.push_back(8'h03);
      send_frame(8'h03, 1'b1);
      wait_idle(100);
      cyc(4);
      chk("ovr_none_after", ocnt - so, 1);
      chk("ovr_pops", pops - sp, 2);

      // deferred reconfiguration
      sl = lowcnt; sp = pops;
      sb.push_back(8'h44);
      fork
         send_frame(8'h44, 1'b1);
         begin
            cyc(3 * 128);
            cfg_pulse(2'b00);
            cyc(128);
            cfg_pulse(2'b01);
            cyc(3 * 128);
            chk("defer_rate_held", gen_baud_rate, 2'b11);
            chk("defer_gen_up", gen_reset_n, 1);
         end
      join
      cyc(10);
      chk("defer_rate_new", gen_baud_rate, 2'b01);
      chk("defer_low_run", lastrun, 2);
      chk("defer_low_total", lowcnt - sl, 2);
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_idle(100);
      cyc(4);
      chk("defer_pops", pops - sp, 2);

      // reset during DATA
      sv = vcnt; sf = fcnt; so = ocnt;
      rx_serial = 1'b0;
      cyc(128);
      rx_serial = 1'b1;
      cyc(256);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("mid_rx_data", rx_data, 0);
      chk("mid_rx_valid", rx_valid, 0);
      chk("mid_busy_rst", busy, 0);
      chk("mid_gen_rate", gen_baud_rate, 2'b10);
      chk("mid_gen_rst_n", gen_reset_n, 0);
      chk("mid_framing", framing_err, 0);
      chk("mid_overrun", overrun_err, 0);
      cyc(1);
      chk("mid_gen_release", gen_reset_n, 1);
      cyc(3 * 128);
      chk("mid_idle", busy, 0);
      chk("mid_no_frm", fcnt - sf, 0);
      chk("mid_no_ovr", ocnt - so, 0);
      chk("mid_no_valid", vcnt - sv, 0);

      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
